// File: rtl/aes_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : aes_io_bridge
// Brief    : Byte-serial handshake bridge between software PIO ports and an
//            AES core. Assembles message/key words, hands them to the core,
//            captures the result and streams it back byte by byte.
// Revision : 1.0 - initial release
// ============================================================================
module aes_io_bridge #(
    parameter int PORT_W     = 8,
    parameter int DATA_BYTES = 16,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [1:0]                   to_hw_sig,
    input  logic [PORT_W-1:0]            to_hw_port,
    output logic [1:0]                   to_sw_sig,
    output logic [PORT_W-1:0]            to_sw_port,
    output logic [DATA_BYTES*PORT_W-1:0] msg_en,
    output logic [DATA_BYTES*PORT_W-1:0] key,
    input  logic [DATA_BYTES*PORT_W-1:0] msg_de,
    output logic                         io_ready,
    input  logic                         aes_ready
);

    localparam int DATA_W = DATA_BYTES * PORT_W;
    localparam int IDX_W  = $clog2(DATA_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_WAIT     = 4'd1,
        S_RD_MSG   = 4'd2,
        S_ACK_MSG  = 4'd3,
        S_RD_KEY   = 4'd4,
        S_ACK_KEY  = 4'd5,
        S_TO_AES   = 4'd6,
        S_FROM_AES = 4'd7,
        S_SEND     = 4'd8,
        S_GOT_ACK  = 4'd9,
        S_FINAL    = 4'd10
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   msg_en_q, msg_en_d;
    logic [DATA_W-1:0]   key_q, key_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [1:0]          to_sw_sig_q, to_sw_sig_d;
    logic [PORT_W-1:0]   to_sw_port_q, to_sw_port_d;
    logic                io_ready_q, io_ready_d;

    // Low bit position of transfer i inside a word, honouring byte order.
    function automatic int slice_lo(input logic [IDX_W-1:0] i);
        if (MSB_FIRST) slice_lo = (DATA_BYTES - 1 - int'(i)) * PORT_W;
        else           slice_lo = int'(i) * PORT_W;
    endfunction

    // Next-state, index and datapath updates; outputs decode from the next state
    // so the registered outputs always match the registered state.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        msg_en_d     = msg_en_q;
        key_d        = key_q;
        res_d        = res_q;
        to_sw_sig_d  = 2'd0;
        to_sw_port_d = '0;
        io_ready_d   = 1'b0;

        case (state_q)
            S_RESET: state_d = S_WAIT;
            S_WAIT: begin
                case (to_hw_sig)
                    2'd1: begin state_d = S_RD_MSG; idx_d = '0; end
                    2'd2: begin state_d = S_RD_KEY; idx_d = '0; end
                    2'd3: state_d = S_TO_AES;
                    default: ;
                endcase
            end
            S_RD_MSG: begin
                msg_en_d[slice_lo(idx_q) +: PORT_W] = to_hw_port;
                if (to_hw_sig == 2'd2) state_d = S_ACK_MSG;
            end
            S_RD_KEY: begin
                key_d[slice_lo(idx_q) +: PORT_W] = to_hw_port;
                if (to_hw_sig == 2'd2) state_d = S_ACK_KEY;
            end
            S_ACK_MSG, S_ACK_KEY: begin
                // Last-transfer test comes first so idx never wraps.
                if (idx_q == LAST_IDX) begin
                    if (to_hw_sig == 2'd0) state_d = S_WAIT;
                end else if (to_hw_sig == 2'd1) begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = (state_q == S_ACK_MSG) ? S_RD_MSG : S_RD_KEY;
                end
            end
            S_TO_AES: begin
                if (aes_ready) begin
                    res_d   = msg_de;
                    state_d = S_FROM_AES;
                end
            end
            S_FROM_AES: begin
                if (to_hw_sig == 2'd0) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                end
            end
            S_SEND: if (to_hw_sig == 2'd1) state_d = S_GOT_ACK;
            S_GOT_ACK: begin
                if (to_hw_sig == 2'd2) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FINAL;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = S_SEND;
                    end
                end
            end
            S_FINAL: if (to_hw_sig == 2'd0) state_d = S_WAIT;
            default: state_d = S_RESET;
        endcase

        case (state_d)
            S_RESET, S_FINAL:   to_sw_sig_d = 2'd3;
            S_RD_MSG, S_RD_KEY: to_sw_sig_d = 2'd1;
            S_TO_AES:           io_ready_d  = 1'b1;
            S_FROM_AES:         to_sw_sig_d = 2'd2;
            S_SEND: begin
                to_sw_sig_d  = 2'd1;
                to_sw_port_d = res_q[slice_lo(idx_d) +: PORT_W];
            end
            S_GOT_ACK: begin
                to_sw_sig_d  = 2'd2;
                to_sw_port_d = res_q[slice_lo(idx_d) +: PORT_W];
            end
            default: ;
        endcase
    end

    // State, index, words and registered outputs; async reset discards partial words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_RESET;
            idx_q        <= '0;
            msg_en_q     <= '0;
            key_q        <= '0;
            res_q        <= '0;
            to_sw_sig_q  <= 2'd3;
            to_sw_port_q <= '0;
            io_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            msg_en_q     <= msg_en_d;
            key_q        <= key_d;
            res_q        <= res_d;
            to_sw_sig_q  <= to_sw_sig_d;
            to_sw_port_q <= to_sw_port_d;
            io_ready_q   <= io_ready_d;
        end
    end

    assign to_sw_sig  = to_sw_sig_q;
    assign to_sw_port = to_sw_port_q;
    assign msg_en     = msg_en_q;
    assign key        = key_q;
    assign io_ready   = io_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_io_bridge
// Brief    : Directed bench for aes_io_bridge; drives one stimulus stream into
//            an MSB-first and an LSB-first instance side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_io_bridge;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   to_hw_sig = 2'd0;
    logic [7:0]   to_hw_port = 8'd0;
    logic [127:0] msg_de = '0;
    logic         aes_ready = 1'b0;

    logic [1:0]   sig_m, sig_l;
    logic [7:0]   port_m, port_l;
    logic [127:0] msg_m, msg_l, key_m, key_l;
    logic         rdy_m, rdy_l;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] RES_VAL = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF;

    aes_io_bridge #(.PORT_W(8), .DATA_BYTES(16), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .to_hw_sig(to_hw_sig), .to_hw_port(to_hw_port),
        .to_sw_sig(sig_m), .to_sw_port(port_m), .msg_en(msg_m), .key(key_m),
        .msg_de(msg_de), .io_ready(rdy_m), .aes_ready(aes_ready)
    );

    aes_io_bridge #(.PORT_W(8), .DATA_BYTES(16), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .to_hw_sig(to_hw_sig), .to_hw_port(to_hw_port),
        .to_sw_sig(sig_l), .to_sw_port(port_l), .msg_en(msg_l), .key(key_l),
        .msg_de(msg_de), .io_ready(rdy_l), .aes_ready(aes_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 16-byte load; sel=1 message, sel=2 key. Optionally parks to_hw_sig=3 in RD at hold_at.
    task automatic load_word(input logic [1:0] sel, input logic [7:0] base, input int hold_at);
        to_hw_port = base; to_hw_sig = sel; tick();
        checks++; if (sig_m !== 2'd1) begin errors++; $display("FAIL load_rd0 got %0d expected 1", sig_m); end
        to_hw_sig = 2'd2; tick();
        checks++; if (sig_m !== 2'd0) begin errors++; $display("FAIL load_ack0 got %0d expected 0", sig_m); end
        for (int i = 1; i < 16; i++) begin
            to_hw_port = base + 8'(i); to_hw_sig = 2'd1; tick();
            checks++; if (sig_m !== 2'd1) begin errors++; $display("FAIL load_rd%0d got %0d expected 1", i, sig_m); end
            if (i == hold_at) begin
                to_hw_sig = 2'd3; repeat (3) tick();
                checks++; if (sig_m !== 2'd1) begin errors++; $display("FAIL hold_rd got %0d expected 1", sig_m); end
            end
            to_hw_sig = 2'd2; tick();
            checks++; if (sig_m !== 2'd0) begin errors++; $display("FAIL load_ack%0d got %0d expected 0", i, sig_m); end
        end
        to_hw_sig = 2'd0; tick();
        checks++; if (sig_m !== 2'd0) begin errors++; $display("FAIL load_end got %0d expected 0", sig_m); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; to_hw_sig = 2'd0;
        repeat (2) tick();
        checks++; if (sig_m !== 2'd3) begin errors++; $display("FAIL rst_sig got %0d expected 3", sig_m); end
        checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL rst_io_ready got %0d expected 0", rdy_m); end
        checks++; if (msg_m !== 128'd0 || key_m !== 128'd0) begin errors++; $display("FAIL rst_words got %h/%h expected 0", msg_m, key_m); end
        checks++; if (port_m !== 8'd0) begin errors++; $display("FAIL rst_port got %h expected 00", port_m); end
        reset_n = 1'b1;
        repeat (2) tick();
        checks++; if (sig_m !== 2'd0) begin errors++; $display("FAIL rst_release got %0d expected 0", sig_m); end
    endtask

    task automatic test_msg_load();
        load_word(2'd1, 8'h00, -1);
        checks++; if (msg_m !== 128'h000102030405060708090A0B0C0D0E0F) begin errors++; $display("FAIL msg_msb got %h expected 000102..0f", msg_m); end
        checks++; if (msg_l !== 128'h0F0E0D0C0B0A09080706050403020100) begin errors++; $display("FAIL msg_lsb got %h expected 0f0e..00", msg_l); end
        checks++; if (key_m !== 128'd0) begin errors++; $display("FAIL msg_key_untouched got %h expected 0", key_m); end
    endtask

    task automatic test_key_load();
        load_word(2'd2, 8'hA0, -1);
        checks++; if (key_l[7:0] !== 8'hA0 || key_l[127:120] !== 8'hAF) begin errors++; $display("FAIL key_lsb_ends got %h/%h expected a0/af", key_l[7:0], key_l[127:120]); end
        checks++; if (key_l !== 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0) begin errors++; $display("FAIL key_lsb got %h expected afae..a0", key_l); end
        checks++; if (key_m !== 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF) begin errors++; $display("FAIL key_msb got %h expected a0a1..af", key_m); end
        checks++; if (msg_m !== 128'h000102030405060708090A0B0C0D0E0F) begin errors++; $display("FAIL key_msg_kept got %h expected 000102..0f", msg_m); end
    endtask

    task automatic test_aes_handoff();
        aes_ready = 1'b1; msg_de = 128'h1111; tick();
        aes_ready = 1'b0; tick();
        checks++; if (sig_m !== 2'd0 || rdy_m !== 1'b0) begin errors++; $display("FAIL aes_ready_ignored got sig %0d rdy %0d expected 0 0", sig_m, rdy_m); end
        to_hw_sig = 2'd3; tick();
        checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL io_ready_set got %0d expected 1", rdy_m); end
        repeat (5) tick();
        checks++; if (rdy_m !== 1'b1 || sig_m !== 2'd0) begin errors++; $display("FAIL to_aes_hold got rdy %0d sig %0d expected 1 0", rdy_m, sig_m); end
        msg_de = RES_VAL; aes_ready = 1'b1; tick();
        checks++; if (sig_m !== 2'd2 || rdy_m !== 1'b0) begin errors++; $display("FAIL from_aes got sig %0d rdy %0d expected 2 0", sig_m, rdy_m); end
        aes_ready = 1'b0; msg_de = 128'h5555_AAAA; tick();
        checks++; if (sig_m !== 2'd2) begin errors++; $display("FAIL from_aes_hold got %0d expected 2", sig_m); end
    endtask

    task automatic test_send_back();
        logic [127:0] r;
        r = RES_VAL;
        to_hw_sig = 2'd0; tick();
        for (int i = 0; i < 16; i++) begin
            checks++; if (sig_m !== 2'd1 || port_m !== r[127-8*i -: 8]) begin errors++; $display("FAIL send%0d got sig %0d port %h expected 1 %h", i, sig_m, port_m, r[127-8*i -: 8]); end
            checks++; if (port_l !== r[8*i +: 8]) begin errors++; $display("FAIL send_lsb%0d got %h expected %h", i, port_l, r[8*i +: 8]); end
            to_hw_sig = 2'd1; tick();
            checks++; if (sig_m !== 2'd2 || port_m !== r[127-8*i -: 8]) begin errors++; $display("FAIL got_ack%0d got sig %0d port %h expected 2 %h", i, sig_m, port_m, r[127-8*i -: 8]); end
            to_hw_sig = 2'd2; tick();
        end
        checks++; if (sig_m !== 2'd3 || port_m !== 8'd0) begin errors++; $display("FAIL final got sig %0d port %h expected 3 00", sig_m, port_m); end
        tick();
        checks++; if (sig_m !== 2'd3) begin errors++; $display("FAIL final_hold got %0d expected 3", sig_m); end
        to_hw_sig = 2'd0; tick();
        checks++; if (sig_m !== 2'd0) begin errors++; $display("FAIL final_to_wait got %0d expected 0", sig_m); end
    endtask

    task automatic test_mid_reset();
        to_hw_port = 8'h50; to_hw_sig = 2'd1; tick();
        to_hw_sig = 2'd2; tick();
        for (int i = 1; i <= 7; i++) begin
            to_hw_port = 8'h50 + 8'(i); to_hw_sig = 2'd1; tick();
            if (i < 7) begin to_hw_sig = 2'd2; tick(); end
        end
        checks++; if (sig_m !== 2'd1) begin errors++; $display("FAIL mid_rd7 got %0d expected 1", sig_m); end
        reset_n = 1'b0; #1;
        checks++; if (msg_m !== 128'd0 || sig_m !== 2'd3) begin errors++; $display("FAIL mid_reset got msg %h sig %0d expected 0 3", msg_m, sig_m); end
        to_hw_sig = 2'd0; tick();
        reset_n = 1'b1; repeat (2) tick();
        checks++; if (sig_m !== 2'd0) begin errors++; $display("FAIL mid_release got %0d expected 0", sig_m); end
        load_word(2'd1, 8'h80, 5);
        checks++; if (msg_m !== 128'h808182838485868788898A8B8C8D8E8F) begin errors++; $display("FAIL fresh_load got %h expected 8081..8f", msg_m); end
        checks++; if (msg_l !== 128'h8F8E8D8C8B8A89888786858483828180) begin errors++; $display("FAIL fresh_load_lsb got %h expected 8f8e..80", msg_l); end
    endtask

    initial begin
        test_reset();
        test_msg_load();
        test_key_load();
        test_aes_handoff();
        test_send_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
